// File: rtl/dmem_arbiter_ctrl_pkg.sv
// Shared types and helpers for the data-cache arbiter/sequencer.
// The request latch and byte merge are sized by the package widths.
package dmem_arbiter_ctrl_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned STRB_W      = DMEM_DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StMerge,
    StResp
  } state_e;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic                   we;
    logic [STRB_W-1:0]      wstrb;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic [DMEM_DATA_W-1:0] merge_bytes(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] new_word,
    input logic [STRB_W-1:0]      strb
  );
    logic [DMEM_DATA_W-1:0] w_out;
    w_out = old_word;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) w_out[8*b +: 8] = new_word[8*b +: 8];
    end
    return w_out;
  endfunction

endpackage

// File: rtl/dmem_arbiter_ctrl_if.sv
// Requester request/response channels plus the data-cache port, as one bundle.
// slave = arbiter view, master = requesters/cache view.
interface dmem_arbiter_ctrl_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    dc_r_enable;
  logic [ADDR_W-1:0]       dc_r_addr;
  logic [DATA_W-1:0]       dc_r_data;
  logic                    dc_w_enable;
  logic [ADDR_W-1:0]       dc_w_addr;
  logic [DATA_W-1:0]       dc_w_data;

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready, dc_r_data,
    output req_ready, rsp_valid, rsp_rdata, dc_r_enable, dc_r_addr, dc_w_enable, dc_w_addr,
           dc_w_data
  );

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready, dc_r_data,
    input  req_ready, rsp_valid, rsp_rdata, dc_r_enable, dc_r_addr, dc_w_enable, dc_w_addr,
           dc_w_data
  );

endinterface

// File: rtl/dmem_arbiter_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts at the port after the last grant.
// Holds last_grant; it only moves when a grant is taken (i_advance).
module dmem_arbiter_ctrl_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_enable,
  input  logic             i_advance,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IdxW-1:0]  o_gnt_idx
);

  logic [IdxW-1:0] r_last;

  always_comb begin
    logic            w_found;
    int unsigned     w_cand;
    logic [IdxW-1:0] w_cand_idx;
    w_found    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    o_gnt      = '0;
    o_gnt_idx  = r_last;
    if (i_enable) begin
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        w_cand     = (32'(r_last) + i) % N_REQ;
        w_cand_idx = w_cand[IdxW-1:0];
        if (!w_found && i_req[w_cand_idx]) begin
          w_found          = 1'b1;
          o_gnt[w_cand_idx] = 1'b1;
          o_gnt_idx        = w_cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IdxW'(N_REQ - 1);
    end else if (i_advance) begin
      r_last <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Shares the data cache among N_REQ requesters; one transaction in flight.
// Partial stores are done as read-modify-write; the response carries the pre-access word.
module dmem_arbiter_ctrl
  import dmem_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_arbiter_ctrl_if.slave   io_bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            r_state;
  state_e            w_state_d;
  dmem_req_t         r_req;
  logic [IdxW-1:0]   r_owner;
  logic [DATA_W-1:0] r_old_word;

  logic [N_REQ-1:0]  w_gnt;
  logic [IdxW-1:0]   w_gnt_idx;
  logic              w_arb_en;
  logic              w_accept;
  logic              w_full;
  logic              w_partial;

  assign w_arb_en  = (r_state == StIdle);
  assign w_accept  = w_arb_en && (|w_gnt);
  assign w_full    = r_req.we && (&r_req.wstrb);
  assign w_partial = r_req.we && (|r_req.wstrb) && !(&r_req.wstrb);

  dmem_arbiter_ctrl_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (io_bus.req_valid),
    .i_enable  (w_arb_en),
    .i_advance (w_accept),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= '0;
      r_owner    <= '0;
      r_old_word <= '0;
    end else begin
      if (w_accept) begin
        r_req.addr  <= io_bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_req.we    <= io_bus.req_we[w_gnt_idx];
        r_req.wstrb <= io_bus.req_wstrb[w_gnt_idx*STRB_W +: STRB_W];
        r_req.wdata <= io_bus.req_wdata[w_gnt_idx*DATA_W +: DATA_W];
        r_owner     <= w_gnt_idx;
      end
      // Read data is combinational from the cache, so the pre-write word is sampled here.
      if (r_state == StAccess) begin
        r_old_word <= io_bus.dc_r_data;
      end
    end
  end

  assign io_bus.dc_r_addr = r_req.addr;
  assign io_bus.dc_w_addr = r_req.addr;
  assign io_bus.rsp_rdata = r_old_word;

  always_comb begin
    w_state_d          = r_state;
    io_bus.req_ready   = '0;
    io_bus.rsp_valid   = '0;
    io_bus.dc_r_enable = 1'b0;
    io_bus.dc_w_enable = 1'b0;
    io_bus.dc_w_data   = '0;
    case (r_state)
      StIdle: begin
        io_bus.req_ready = w_gnt;
        if (w_accept) w_state_d = StAccess;
      end
      StAccess: begin
        io_bus.dc_r_enable = 1'b1;
        if (w_full) begin
          io_bus.dc_w_enable = 1'b1;
          io_bus.dc_w_data   = r_req.wdata;
          w_state_d          = StResp;
        end else if (w_partial) begin
          w_state_d = StMerge;
        end else begin
          w_state_d = StResp;
        end
      end
      StMerge: begin
        io_bus.dc_w_enable = 1'b1;
        io_bus.dc_w_data   = merge_bytes(r_old_word, r_req.wdata, r_req.wstrb);
        w_state_d          = StResp;
      end
      StResp: begin
        io_bus.rsp_valid[r_owner] = 1'b1;
        if (io_bus.rsp_ready[r_owner]) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule
